// File: rtl/motor_encoder_decoder.sv
// Quadrature encoder receiver: synchronizes and glitch-filters A/B, decodes 4x
// into a signed position, and reports direction, running status and edge period.
module motor_encoder_decoder #(
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER_LEN   = 4,
  parameter int POS_WIDTH    = 32,
  parameter int PER_WIDTH    = 32,
  parameter int STALL_CYCLES = 1000000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enc_a,
  input  logic                        enc_b,
  input  logic                        clear_pos,
  input  logic                        error_clr,
  output logic signed [POS_WIDTH-1:0] position,
  output logic                        motor_dir,
  output logic                        motor_is_running,
  output logic [PER_WIDTH-1:0]        edge_period,
  output logic                        period_valid,
  output logic                        quad_error
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int IW = $clog2(STALL_CYCLES + 1);
  localparam logic [FW-1:0] RUN_LAST = FW'(FILTER_LEN - 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(STALL_CYCLES);
  localparam logic [IW-1:0] IDLE_LAST = IW'(STALL_CYCLES - 1);
  localparam logic [PER_WIDTH-1:0] PER_MAX = '1;
  localparam logic signed [POS_WIDTH-1:0] POS_ONE = 1;

  typedef enum logic {ST_UNPRIMED, ST_PRIMED} state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sync_a;
  logic [SYNC_STAGES-1:0]  sync_b;
  logic [SYNC_STAGES-1:0]  sync_vld;
  logic [1:0]              sync_ab;
  logic [1:0]              acc_ab;
  logic [1:0]              prev_ab;
  logic [FW-1:0]           run_cnt [2];
  logic [FW-1:0]           prime_cnt;
  logic [IW-1:0]           idle_cnt;
  logic [PER_WIDTH-1:0]    per_cnt;
  logic                    stable;
  logic                    step;
  logic                    step_cw;
  logic                    illegal;

  // sync_vld marks when the chain holds only post-reset samples of the pins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_a   <= '0;
      sync_b   <= '0;
      sync_vld <= '0;
    end else begin
      sync_a   <= {sync_a[SYNC_STAGES-2:0], enc_a};
      sync_b   <= {sync_b[SYNC_STAGES-2:0], enc_b};
      sync_vld <= {sync_vld[SYNC_STAGES-2:0], 1'b1};
    end
  end

  always_comb begin
    sync_ab = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};
    stable  = sync_vld[SYNC_STAGES-1] && (&sync_a || ~|sync_a) && (&sync_b || ~|sync_b);
    step    = 1'b0;
    illegal = 1'b0;
    if (state == ST_PRIMED) begin
      step    = ((acc_ab ^ prev_ab) == 2'b01) || ((acc_ab ^ prev_ab) == 2'b10);
      illegal = (acc_ab ^ prev_ab) == 2'b11;
    end
    // Along 00->01->11->10->00 the new B always differs from the old A
    step_cw = prev_ab[1] ^ acc_ab[0];
  end

  // Priming FSM and per-channel glitch filters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_UNPRIMED;
      prime_cnt  <= '0;
      acc_ab     <= '0;
      prev_ab    <= '0;
      run_cnt[0] <= '0;
      run_cnt[1] <= '0;
    end else begin
      case (state)
        ST_UNPRIMED: begin
          if (!stable) begin
            prime_cnt <= '0;
          end else if (prime_cnt == RUN_LAST) begin
            acc_ab    <= sync_ab;
            prev_ab   <= sync_ab;
            prime_cnt <= '0;
            state     <= ST_PRIMED;
          end else begin
            prime_cnt <= prime_cnt + FW'(1);
          end
        end
        ST_PRIMED: begin
          prev_ab <= acc_ab;
          for (int i = 0; i < 2; i++) begin
            if (sync_ab[i] == acc_ab[i]) begin
              run_cnt[i] <= '0;
            end else if (run_cnt[i] == RUN_LAST) begin
              acc_ab[i]  <= sync_ab[i];
              run_cnt[i] <= '0;
            end else begin
              run_cnt[i] <= run_cnt[i] + FW'(1);
            end
          end
        end
        default: state <= ST_UNPRIMED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      position         <= '0;
      motor_dir        <= 1'b1;
      motor_is_running <= 1'b0;
      edge_period      <= '0;
      period_valid     <= 1'b0;
      quad_error       <= 1'b0;
      idle_cnt         <= '0;
      per_cnt          <= '0;
    end else begin
      if (clear_pos) begin
        position <= '0;
      end else if (step) begin
        position <= step_cw ? (position + POS_ONE) : (position - POS_ONE);
      end

      if (illegal) begin
        quad_error <= 1'b1;
      end else if (error_clr) begin
        quad_error <= 1'b0;
      end

      period_valid <= step && motor_is_running;
      if (step) begin
        motor_dir        <= step_cw;
        motor_is_running <= 1'b1;
        idle_cnt         <= '0;
        per_cnt          <= '0;
        // Only an edge that follows another edge yields a meaningful period
        if (motor_is_running) begin
          edge_period <= (per_cnt == PER_MAX) ? PER_MAX : (per_cnt + PER_WIDTH'(1));
        end
      end else begin
        if (idle_cnt != IDLE_MAX) begin
          idle_cnt <= idle_cnt + IW'(1);
        end
        if (idle_cnt == IDLE_LAST) begin
          motor_is_running <= 1'b0;
        end
        if (per_cnt != PER_MAX) begin
          per_cnt <= per_cnt + PER_WIDTH'(1);
        end
      end
    end
  end

endmodule
